// File: rtl/sqrt_seq_unit_if.sv
// Start/done handshake and result bundle for sqrt_seq_unit.
// master drives St/N; slave returns done, busy, sqrt, rem.
interface sqrt_seq_unit_if #(
  parameter int W = 8
);
  logic           St;
  logic [W-1:0]   N;
  logic           done;
  logic           busy;
  logic [W/2-1:0] sqrt;
  logic [W/2:0]   rem;

  modport master (
    output St, N,
    input  done, busy, sqrt, rem
  );

  modport slave (
    input  St, N,
    output done, busy, sqrt, rem
  );
endinterface

// File: rtl/sqrt_seq_unit.sv
// Sequential restoring square root, one root bit per clock.
// Ports: clk, rstN (async low), bus (St/N in; done/busy/sqrt/rem out).
module sqrt_seq_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstN,
  sqrt_seq_unit_if.slave bus
);

  localparam int H  = W / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  generate
    if ((W % 2) != 0 || W < 2 || W > 32) begin : g_bad_w
      $error("sqrt_seq_unit: W must be even, 2..32");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    DONE
  } state_t;

  state_t st, st_n;

  logic [W-1:0]  x;
  logic [H-1:0]  r;
  logic [H:0]    q;
  logic [CW-1:0] cnt;
  logic          done_q;
  logic          busy_q;
  logic [H-1:0]  sqrt_q;
  logic [H:0]    rem_q;

  logic [H+1:0]  qp;
  logic [H+1:0]  t;
  logic [H+1:0]  df;
  logic          ge;
  logic [H:0]    qn;
  logic [H:0]    rw;
  logic [H-1:0]  rn;
  logic          last;

  assign last = (cnt == '0);

  // q never exceeds 2r, so its top bit is clear
  // whenever it is shifted into qp.
  always_comb begin
    qp = {q[H-1:0], x[W-1:W-2]};
    t  = {r, 2'b01};
    df = qp - t;
    ge = (qp >= t);
    qn = ge ? df[H:0] : qp[H:0];
    rw = {r, ge};
    rn = rw[H-1:0];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) st <= IDLE;
    else       st <= st_n;
  end

  always_comb begin
    st_n = IDLE;
    case (st)
      IDLE: st_n = bus.St ? LOAD : IDLE;
      LOAD: st_n = CALC;
      CALC: st_n = last ? DONE : CALC;
      DONE: st_n = bus.St ? DONE : IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      x      <= '0;
      r      <= '0;
      q      <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      sqrt_q <= '0;
      rem_q  <= '0;
    end else begin
      case (st)
        LOAD: begin
          x      <= bus.N;
          r      <= '0;
          q      <= '0;
          cnt    <= CW'(H - 1);
          busy_q <= 1'b1;
        end
        CALC: begin
          x <= x << 2;
          q <= qn;
          r <= rn;
          if (last) begin
            sqrt_q <= rn;
            rem_q  <= qn;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!bus.St) done_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.sqrt = sqrt_q;
  assign bus.rem  = rem_q;

endmodule
